// File: rtl/module_matrix_scanner_if.sv
// Keypad scanner bus: enable, scan-rate strobe and column sense lines in,
// row drive and debounced key event out. Grouped so the scanner and
// whatever sits on the pin side share one definition of the widths.
interface module_matrix_scanner_if #(
    parameter int ROWS = 4,
    parameter int COLS = 4
);
    localparam int RW = $clog2(ROWS);
    localparam int KW = $clog2(ROWS * COLS);

    logic            en_i;
    logic            refresh_i;
    logic [COLS-1:0] col_i;
    logic [ROWS-1:0] row_o;
    logic [RW-1:0]   conta_o;
    logic            key_valid_o;
    logic [KW-1:0]   key_code_o;
    logic            key_held_o;

    // Pin / controller side: drives enable, strobe and columns.
    modport master (
        output en_i,
        output refresh_i,
        output col_i,
        input  row_o,
        input  conta_o,
        input  key_valid_o,
        input  key_code_o,
        input  key_held_o
    );

    // Scanner side.
    modport slave (
        input  en_i,
        input  refresh_i,
        input  col_i,
        output row_o,
        output conta_o,
        output key_valid_o,
        output key_code_o,
        output key_held_o
    );
endinterface

// File: rtl/module_matrix_scanner.sv
// Row-scan sequencer for a ROWS x COLS matrix keypad. Drives a one-hot row
// strobe, synchronises the column lines and the scan-rate strobe, debounces
// both press and release over DEBOUNCE_TICKS refresh ticks and reports each
// accepted press as a one-cycle event carrying a linear key code.
module module_matrix_scanner #(
    parameter int ROWS           = 4,
    parameter int COLS           = 4,
    parameter int DEBOUNCE_TICKS = 4
) (
    input  logic                    clk,
    input  logic                    rst_n_i,
    module_matrix_scanner_if.slave  bus
);
    localparam int RW   = $clog2(ROWS);
    localparam int KW   = $clog2(ROWS * COLS);
    localparam int CW   = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int CNTW = $clog2(DEBOUNCE_TICKS + 1);

    localparam logic [RW-1:0]   LAST_ROW = RW'(ROWS - 1);
    localparam logic [CNTW-1:0] CNT_ONE  = CNTW'(1);
    localparam logic [CNTW-1:0] CNT_DONE = CNTW'(DEBOUNCE_TICKS);
    localparam logic [KW-1:0]   COLS_K   = KW'(COLS);

    typedef enum logic [1:0] {
        SCAN,
        DEB_PRESS,
        PRESSED,
        DEB_REL
    } state_t;

    // Synchroniser and edge-history flops.
    logic            refSync1_q;
    logic            refSync2_q;
    logic            refHist_q;
    logic [COLS-1:0] colSync1_q;
    logic [COLS-1:0] colSync2_q;

    // Scanner state and registered outputs.
    state_t          state_q;
    logic [CNTW-1:0] cnt_q;
    logic [RW-1:0]   conta_q;
    logic [ROWS-1:0] row_q;
    logic [CW-1:0]   capCol_q;
    logic            keyValid_q;
    logic [KW-1:0]   keyCode_q;
    logic            keyHeld_q;

    // Derived combinational values.
    logic            tick;
    logic            hit;
    logic            capColSet;
    logic [CW-1:0]   activeCol;
    logic [RW-1:0]   conta_d;
    logic [ROWS-1:0] rowNext_d;
    logic [CNTW-1:0] cntInc_d;
    logic [KW-1:0]   pressCode_d;

    // Bring the asynchronous strobe and columns into the clock domain; the
    // whole chain freezes while disabled so no edge is invented on resume.
    always_ff @(posedge clk or negedge rst_n_i) begin
        if (!rst_n_i) begin
            refSync1_q <= 1'b0;
            refSync2_q <= 1'b0;
            refHist_q  <= 1'b0;
            colSync1_q <= '0;
            colSync2_q <= '0;
        end else if (bus.en_i) begin
            refSync1_q <= bus.refresh_i;
            refSync2_q <= refSync1_q;
            refHist_q  <= refSync2_q;
            colSync1_q <= bus.col_i;
            colSync2_q <= colSync1_q;
        end
    end

    assign tick      = bus.en_i & refSync2_q & ~refHist_q;
    assign hit       = |colSync2_q;
    assign capColSet = colSync2_q[capCol_q];
    assign cntInc_d  = cnt_q + CNT_ONE;
    assign conta_d   = (conta_q == LAST_ROW) ? '0 : conta_q + RW'(1);
    assign rowNext_d = ROWS'(1) << conta_d;

    // Lowest-numbered closed column wins when several are closed at once.
    always_comb begin
        activeCol = '0;
        for (int c = COLS - 1; c >= 0; c--) begin
            if (colSync2_q[c]) begin
                activeCol = CW'(c);
            end
        end
    end

    // Code for a press accepted this tick. During press debounce the active
    // column equals the captured one, so the live column serves both paths.
    assign pressCode_d = KW'(conta_q) * COLS_K + KW'(activeCol);

    // Scan / debounce state machine; all outputs are registered here.
    always_ff @(posedge clk or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= SCAN;
            cnt_q      <= '0;
            conta_q    <= '0;
            row_q      <= ROWS'(1);
            capCol_q   <= '0;
            keyValid_q <= 1'b0;
            keyCode_q  <= '0;
            keyHeld_q  <= 1'b0;
        end else begin
            keyValid_q <= 1'b0;
            if (tick) begin
                unique case (state_q)
                    SCAN: begin
                        if (hit) begin
                            capCol_q <= activeCol;
                            cnt_q    <= CNT_ONE;
                            if (DEBOUNCE_TICKS == 1) begin
                                state_q    <= PRESSED;
                                keyValid_q <= 1'b1;
                                keyCode_q  <= pressCode_d;
                                keyHeld_q  <= 1'b1;
                            end else begin
                                state_q <= DEB_PRESS;
                            end
                        end else begin
                            conta_q <= conta_d;
                            row_q   <= rowNext_d;
                        end
                    end
                    DEB_PRESS: begin
                        if (hit && (activeCol == capCol_q)) begin
                            cnt_q <= cntInc_d;
                            if (cntInc_d == CNT_DONE) begin
                                state_q    <= PRESSED;
                                keyValid_q <= 1'b1;
                                keyCode_q  <= pressCode_d;
                                keyHeld_q  <= 1'b1;
                            end
                        end else begin
                            // Bounce: give up and rescan this same row.
                            state_q <= SCAN;
                            cnt_q   <= '0;
                        end
                    end
                    PRESSED: begin
                        if (!capColSet) begin
                            if (DEBOUNCE_TICKS == 1) begin
                                state_q   <= SCAN;
                                cnt_q     <= '0;
                                keyHeld_q <= 1'b0;
                            end else begin
                                state_q <= DEB_REL;
                                cnt_q   <= CNT_ONE;
                            end
                        end
                    end
                    DEB_REL: begin
                        if (capColSet) begin
                            // Release bounce: same key, so no new event.
                            state_q <= PRESSED;
                        end else begin
                            cnt_q <= cntInc_d;
                            if (cntInc_d == CNT_DONE) begin
                                state_q   <= SCAN;
                                cnt_q     <= '0;
                                keyHeld_q <= 1'b0;
                            end
                        end
                    end
                endcase
            end
        end
    end

    assign bus.row_o       = row_q;
    assign bus.conta_o     = conta_q;
    assign bus.key_valid_o = keyValid_q & bus.en_i;
    assign bus.key_code_o  = keyCode_q;
    assign bus.key_held_o  = keyHeld_q;

endmodule

// File: tb/tb_module_matrix_scanner.sv
// Bench for module_matrix_scanner: a 4x4 scanner with 4-tick debounce and a
// 3x3 scanner with single-tick debounce, each fed by a keypad model that
// closes column c whenever the driven row r has key r*COLS+c pressed.
module tb_module_matrix_scanner;

    typedef struct {
        int          sel;
        logic [15:0] keys;
        logic        en;
        int          conta;
        logic        held;
        logic        valid;
        int          code;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        refresh;
    logic        enA;
    logic        enB;
    logic [15:0] keysA;
    logic [8:0]  keysB;
    logic [3:0]  colA;
    logic [2:0]  colB;

    int checks = 0;
    int fails  = 0;
    int scoreQ[$];
    vec_t tbl[$];
    int aEnd;

    always #5 clk = ~clk;

    module_matrix_scanner_if #(.ROWS(4), .COLS(4)) busA ();
    module_matrix_scanner_if #(.ROWS(3), .COLS(3)) busB ();

    assign busA.en_i      = enA;
    assign busA.refresh_i = refresh;
    assign busA.col_i     = colA;
    assign busB.en_i      = enB;
    assign busB.refresh_i = refresh;
    assign busB.col_i     = colB;

    module_matrix_scanner #(.ROWS(4), .COLS(4), .DEBOUNCE_TICKS(4)) dutA (
        .clk     (clk),
        .rst_n_i (rst_n),
        .bus     (busA)
    );

    module_matrix_scanner #(.ROWS(3), .COLS(3), .DEBOUNCE_TICKS(1)) dutB (
        .clk     (clk),
        .rst_n_i (rst_n),
        .bus     (busB)
    );

    // Keypad matrix model: a pressed key shorts its row to its column.
    always_comb begin
        colA = '0;
        colB = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keysA[r*4+c] && busA.row_o[r]) colA[c] = 1'b1;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                if (keysB[r*3+c] && busB.row_o[r]) colB[c] = 1'b1;
    end

    // Scoreboard for the 4x4 scanner: every pulse must match a queued code.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && busA.key_valid_o === 1'b1) begin
            checks++;
            if (scoreQ.size() == 0) begin
                fails++;
                $display("[TB] FAIL keyEvent unexpected: actual code %0d, required no event", busA.key_code_o);
            end else begin
                int exp;
                exp = scoreQ.pop_front();
                if (32'(busA.key_code_o) !== exp) begin
                    fails++;
                    $display("[TB] FAIL keyEvent code: actual %0d, required %0d", busA.key_code_o, exp);
                end
            end
        end
    end

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: actual %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic addVec(input int sel, input logic [15:0] keys, input logic en,
                          input int conta, input logic held, input logic valid, input int code);
        vec_t v;
        v.sel = sel; v.keys = keys; v.en = en; v.conta = conta;
        v.held = held; v.valid = valid; v.code = code;
        tbl.push_back(v);
    endtask

    // Set keys/enable, let the columns settle, then raise refresh and wait
    // until just after the edge that ends the resulting tick cycle.
    task automatic applyStimulus(input vec_t v);
        if (v.sel == 0) begin
            keysA = v.keys;
            enA   = v.en;
            if (v.valid) scoreQ.push_back(v.code);
        end else begin
            keysB = v.keys[8:0];
            enB   = v.en;
        end
        repeat (2) @(negedge clk);
        refresh = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic checkOutput(input vec_t v, input string tag);
        logic [31:0] aConta, aRow, aHeld, aValid, aCode;
        if (v.sel == 0) begin
            aConta = 32'(busA.conta_o);
            aRow   = 32'(busA.row_o);
            aHeld  = 32'(busA.key_held_o);
            aValid = 32'(busA.key_valid_o);
            aCode  = 32'(busA.key_code_o);
        end else begin
            aConta = 32'(busB.conta_o);
            aRow   = 32'(busB.row_o);
            aHeld  = 32'(busB.key_held_o);
            aValid = 32'(busB.key_valid_o);
            aCode  = 32'(busB.key_code_o);
        end
        cmp({tag, " conta"}, aConta, 32'(v.conta));
        cmp({tag, " row"},   aRow,   32'(1) << v.conta);
        cmp({tag, " held"},  aHeld,  32'(v.held));
        cmp({tag, " valid"}, aValid, 32'(v.valid));
        cmp({tag, " code"},  aCode,  32'(v.code));
    endtask

    task automatic runRange(input int first, input int last);
        for (int i = first; i < last; i++) begin
            applyStimulus(tbl[i]);
            checkOutput(tbl[i], $sformatf("vec%0d", i));
            refresh = 1'b0;
            repeat (3) @(negedge clk);
        end
    endtask

    initial begin
        vec_t r;

        // 4x4, debounce 4: free scan, key (2,1), release, press bounce,
        // release bounce, second key ignored, two columns, enable freeze.
        for (int i = 1; i <= 9; i++) addVec(0, 16'h0000, 1, i % 4, 0, 0, 0);
        for (int i = 0; i < 4; i++)  addVec(0, 16'h0200, 1, 2, 0, 0, 0);
        addVec(0, 16'h0200, 1, 2, 1, 1, 9);
        for (int i = 0; i < 2; i++)  addVec(0, 16'h0200, 1, 2, 1, 0, 9);
        for (int i = 0; i < 3; i++)  addVec(0, 16'h0000, 1, 2, 1, 0, 9);
        addVec(0, 16'h0000, 1, 2, 0, 0, 9);
        addVec(0, 16'h0000, 1, 3, 0, 0, 9);
        for (int i = 0; i < 3; i++)  addVec(0, 16'h0002, 1, 0, 0, 0, 9);
        addVec(0, 16'h0000, 1, 0, 0, 0, 9);
        for (int i = 0; i < 3; i++)  addVec(0, 16'h0002, 1, 0, 0, 0, 9);
        addVec(0, 16'h0002, 1, 0, 1, 1, 1);
        for (int i = 0; i < 2; i++)  addVec(0, 16'h0000, 1, 0, 1, 0, 1);
        for (int i = 0; i < 2; i++)  addVec(0, 16'h0002, 1, 0, 1, 0, 1);
        addVec(0, 16'h000A, 1, 0, 1, 0, 1);
        for (int i = 0; i < 3; i++)  addVec(0, 16'h0000, 1, 0, 1, 0, 1);
        addVec(0, 16'h0000, 1, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++)  addVec(0, 16'h000A, 1, 0, 0, 0, 1);
        addVec(0, 16'h000A, 1, 0, 1, 1, 1);
        for (int i = 0; i < 3; i++)  addVec(0, 16'h0000, 1, 0, 1, 0, 1);
        addVec(0, 16'h0000, 1, 0, 0, 0, 1);
        addVec(0, 16'h0000, 1, 1, 0, 0, 1);
        for (int i = 0; i < 10; i++) addVec(0, 16'h0010, 0, 1, 0, 0, 1);
        for (int i = 0; i < 3; i++)  addVec(0, 16'h0010, 1, 1, 0, 0, 1);
        addVec(0, 16'h0010, 1, 1, 1, 1, 4);
        for (int i = 0; i < 3; i++)  addVec(0, 16'h0000, 1, 1, 1, 0, 4);
        addVec(0, 16'h0000, 1, 1, 0, 0, 4);
        for (int i = 0; i < 2; i++)  addVec(0, 16'h0040, 1, 1, 0, 0, 4);
        aEnd = tbl.size();

        // After the reset in DEB_PRESS: scan restarts from row 0, then the
        // 4x4 is parked and the 3x3 single-tick scanner is exercised.
        addVec(0, 16'h0000, 1, 1, 0, 0, 0);
        addVec(0, 16'h0000, 0, 1, 0, 0, 0);
        for (int i = 1; i <= 6; i++) addVec(1, 16'h0000, 1, i % 3, 0, 0, 0);
        addVec(1, 16'h0100, 1, 1, 0, 0, 0);
        addVec(1, 16'h0100, 1, 2, 0, 0, 0);
        addVec(1, 16'h0100, 1, 2, 1, 1, 8);
        addVec(1, 16'h0100, 1, 2, 1, 0, 8);
        addVec(1, 16'h0000, 1, 2, 0, 0, 8);
        addVec(1, 16'h0000, 1, 0, 0, 0, 8);

        rst_n   = 1'b0;
        refresh = 1'b0;
        enA     = 1'b0;
        enB     = 1'b0;
        keysA   = '0;
        keysB   = '0;
        repeat (3) @(negedge clk);

        r.sel = 0; r.keys = '0; r.en = 0; r.conta = 0; r.held = 0; r.valid = 0; r.code = 0;
        checkOutput(r, "resetA");
        r.sel = 1;
        checkOutput(r, "resetB");

        rst_n = 1'b1;
        @(negedge clk);
        runRange(0, aEnd);

        // Reset mid-debounce must clear everything before any clock edge.
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        r.sel = 0;
        checkOutput(r, "midReset");
        @(negedge clk);
        rst_n = 1'b1;
        keysA = '0;
        @(negedge clk);

        runRange(aEnd, tbl.size());

        cmp("scoreboard drained", 32'(scoreQ.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
